put_motion_code: RTL and testbench

PUT_MOTION_CODE -- requirements
Module: put_motion_code

---
 rtl/put_motion_code_pkg.sv | 45 ++++
 rtl/put_motion_code_lut.sv | 19 +
 rtl/put_motion_code.sv | 121 ++++++++++++
 tb/tb_put_motion_code.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/put_motion_code_pkg.sv
// Shared constants for the MPEG-2 motion_code VLC encoder: legal range,
// codeword sizing, FSM state encoding and the magnitude->prefix table.
package put_motion_code_pkg;

  localparam int MAX_VLC_LEN = 11;
  localparam int PREFIX_W    = 10;
  localparam int NUM_MAG     = 17;

  localparam logic signed [5:0] MCODE_MIN = -6'sd16;
  localparam logic signed [5:0] MCODE_MAX = 6'sd16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Prefix patterns MSB-aligned in 10 bits; entry 0 is the rightmost element.
  localparam logic [NUM_MAG-1:0][PREFIX_W-1:0] PREFIX_TBL = {
    10'b0000001100,  // 16
    10'b0000001101,  // 15
    10'b0000001110,  // 14
    10'b0000001111,  // 13
    10'b0000010000,  // 12
    10'b0000010001,  // 11
    10'b0000010010,  // 10
    10'b0000010100,  // 9
    10'b0000010110,  // 8
    10'b0000011000,  // 7
    10'b0000100000,  // 6
    10'b0000101000,  // 5
    10'b0000110000,  // 4
    10'b0001000000,  // 3
    10'b0010000000,  // 2
    10'b0100000000,  // 1
    10'b1000000000   // 0
  };

  localparam logic [NUM_MAG-1:0][3:0] PLEN_TBL = {
    4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10,
    4'd9,  4'd9,  4'd9,
    4'd7,  4'd7,  4'd7,
    4'd6,  4'd4,  4'd3,  4'd2,  4'd1
  };

endpackage

// File: rtl/put_motion_code_lut.sv
// Combinational magnitude -> (MSB-aligned prefix, prefix length) lookup.
module mv_vlc_lut
  import put_motion_code_pkg::*;
(
  input  logic [4:0]          mag_i,
  output logic [PREFIX_W-1:0] prefix_o,
  output logic [3:0]          plen_o
);

  always_comb begin
    prefix_o = '0;
    plen_o   = '0;
    if (mag_i <= 5'd16) begin
      prefix_o = PREFIX_TBL[mag_i];
      plen_o   = PLEN_TBL[mag_i];
    end
  end

endmodule

// File: rtl/put_motion_code.sv
// MPEG-2 motion_code VLC encoder: accepts one signed mcode, builds the
// codeword (prefix + sign) and serializes it MSB first under out_ready.
module put_motion_code
  import put_motion_code_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  mcode,
  output logic        out_bit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] code,
  output logic [3:0]  len,
  output logic        done,
  output logic        err
);

  state_e      state_q, state_d;
  logic [10:0] code_q, code_d;
  logic [10:0] sh_q, sh_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [4:0]          mag_w;
  logic                legal_w;
  logic                has_sign_w;
  logic [PREFIX_W-1:0] prefix_w;
  logic [3:0]          plen_w;
  logic [3:0]          sign_pos_w;
  logic [3:0]          len_w;
  logic [10:0]         code_w;
  logic                last_bit_w;

  // Negating only the low 5 bits keeps -16 at 5'b10000 without overflow.
  assign mag_w      = mcode[5] ? (5'd0 - mcode[4:0]) : mcode[4:0];
  assign legal_w    = ($signed(mcode) >= MCODE_MIN) && ($signed(mcode) <= MCODE_MAX);
  assign has_sign_w = (mag_w != 5'd0);

  mv_vlc_lut u_lut (
    .mag_i    (mag_w),
    .prefix_o (prefix_w),
    .plen_o   (plen_w)
  );

  assign sign_pos_w = 4'(MAX_VLC_LEN - 1) - plen_w;
  assign code_w     = {prefix_w, 1'b0}
                    | (has_sign_w ? ({10'd0, mcode[5]} << sign_pos_w) : 11'd0);
  assign len_w      = plen_w + {3'd0, has_sign_w};
  assign last_bit_w = (cnt_q == (len_q - 4'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      sh_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      sh_q    <= sh_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // IDLE | waiting for an mcode ; SHIFT | serializing the loaded codeword
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    sh_d    = sh_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (legal_w) begin
            code_d  = code_w;
            sh_d    = code_w;
            len_d   = len_w;
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (out_ready) begin
          sh_d = {sh_q[9:0], 1'b0};
          if (last_bit_w) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_SHIFT);
  assign out_bit   = out_valid & sh_q[10];
  assign code      = code_q;
  assign len       = len_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_put_motion_code.sv
// Bench for put_motion_code: string-table reference model, per-cycle compare,
// directed literal cases, random stream and a decoder round-trip.
module tb_put_motion_code;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_bit, out_valid, out_ready, done, err;
  logic [5:0]  mcode;
  logic [10:0] code;
  logic [3:0]  len;

  always #5 clk = ~clk;

  put_motion_code dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mcode(mcode), .out_bit(out_bit), .out_valid(out_valid),
    .out_ready(out_ready), .code(code), .len(len), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  string PFX [17] = '{"1", "01", "001", "0001", "000011", "0000101", "0000100",
                      "0000011", "000001011", "000001010", "000001001",
                      "0000010001", "0000010000", "0000001111", "0000001110",
                      "0000001101", "0000001100"};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic string codeword(input int v);
    int    mag = (v < 0) ? -v : v;
    string s   = PFX[mag];
    if (mag != 0) s = {s, (v < 0) ? "1" : "0"};
    return s;
  endfunction

  // Reference model: remaining bits of the current symbol live in a queue.
  bit          mq[$];
  logic [10:0] m_code = '0;
  logic [3:0]  m_len  = '0;
  bit          m_done = 1'b0;
  bit          m_err  = 1'b0;
  int          m_acc[$];
  bit          cap[$];

  always @(posedge clk) begin
    int    v;
    string s;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      mq.delete();
      m_code = '0;
      m_len  = '0;
    end else if (mq.size() != 0) begin
      if (out_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_done = 1'b1;
      end
    end else if (in_valid) begin
      v = int'($signed(mcode));
      if (v >= -16 && v <= 16) begin
        s      = codeword(v);
        m_code = '0;
        for (int i = 0; i < s.len(); i++) begin
          mq.push_back(s.getc(i) == "1");
          m_code[10-i] = (s.getc(i) == "1");
        end
        m_len = 4'(s.len());
        m_acc.push_back(v);
      end else begin
        m_err = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk("in_ready",  32'(in_ready),  32'(mq.size() == 0));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("out_bit",   32'(out_bit),   32'((mq.size() != 0) ? mq[0] : 1'b0));
      chk("code",      32'(code),      32'(m_code));
      chk("len",       32'(len),       32'(m_len));
      chk("done",      32'(done),      32'(m_done));
      chk("err",       32'(err),       32'(m_err));
      if (!rst && out_valid === 1'b1 && out_ready) cap.push_back(out_bit);
    end
  end

  function automatic void decode(input bit s[$], input int start, output int res[$], output bit ok);
    int idx = start;
    ok = 1'b1;
    res.delete();
    while (idx < s.size()) begin
      int    mag = -1;
      string p;
      for (int m = 0; m < 17; m++) begin
        bit hit;
        p   = PFX[m];
        hit = (idx + p.len() <= s.size());
        for (int k = 0; k < p.len() && hit; k++)
          if (s[idx+k] != (p.getc(k) == "1")) hit = 1'b0;
        if (hit && mag < 0) mag = m;
      end
      if (mag < 0) begin ok = 1'b0; return; end
      p   = PFX[mag];
      idx = idx + p.len();
      if (mag == 0) res.push_back(0);
      else begin
        if (idx >= s.size()) begin ok = 1'b0; return; end
        res.push_back(s[idx] ? -mag : mag);
        idx++;
      end
    end
  endfunction

  task automatic collect(input int n, output logic [31:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("collect_valid", 32'(out_valid), 32'd1);
      bits = {bits[30:0], out_bit};
    end
  endtask

  task automatic push(input int v);
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      in_valid  = 1'b1;
      mcode     = 6'($urandom);
      out_ready = ($urandom % 2) == 1;
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("push_timeout", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    mcode     = 6'(v);
    out_ready = ($urandom % 2) == 1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("drain_timeout", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          cstart, astart;
    int          res[$];
    bit          ok;
    int          bad [4] = '{20, -17, 17, -32};

    rst = 1'b1; in_valid = 1'b0; mcode = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_len", 32'(len), 32'd0);

    // mcode 0: single bit, no sign
    in_valid = 1'b1; mcode = 6'd0; out_ready = 1'b1;
    collect(1, v);
    chk("m0_bit", v, 32'd1);
    chk("m0_len", 32'(len), 32'd1);
    chk("m0_code", 32'(code), 32'(11'b10000000000));
    @(negedge clk);
    chk("m0_done", 32'(done), 32'd1);
    chk("m0_out_valid", 32'(out_valid), 32'd0);

    // mcode -3
    in_valid = 1'b1; mcode = 6'(-3); out_ready = 1'b1;
    collect(5, v);
    chk("m3_bits", v, 32'b00011);
    chk("m3_len", 32'(len), 32'd5);
    chk("m3_code", 32'(code), 32'(11'b00011000000));
    @(negedge clk);
    chk("m3_done", 32'(done), 32'd1);

    // mcode +16 with a 3-cycle stall on the first bit
    in_valid = 1'b1; mcode = 6'd16; out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk("p16_hold_valid", 32'(out_valid), 32'd1);
      chk("p16_hold_bit", 32'(out_bit), 32'd0);
    end
    collect(11, v);
    chk("p16_bits", v, 32'(11'b00000011000));
    chk("p16_len", 32'(len), 32'd11);
    @(negedge clk);
    chk("p16_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("p16_done_once", 32'(done), 32'd0);

    // out-of-range values: err pulse, nothing emitted, code/len kept
    foreach (bad[i]) begin
      in_valid = 1'b1; mcode = 6'(bad[i]);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bad_err", 32'(err), 32'd1);
      chk("bad_out_valid", 32'(out_valid), 32'd0);
      chk("bad_in_ready", 32'(in_ready), 32'd1);
      chk("bad_code_kept", 32'(code), 32'(11'b00000011000));
      chk("bad_len_kept", 32'(len), 32'd11);
      @(negedge clk);
      chk("bad_err_clear", 32'(err), 32'd0);
    end

    // +7 interrupted by reset after 3 bits, then -1
    in_valid = 1'b1; mcode = 6'd7; out_ready = 1'b1;
    collect(3, v);
    chk("p7_bits", v, 32'b000);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; mcode = 6'd2;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("p7_rst_out_valid", 32'(out_valid), 32'd0);
    chk("p7_rst_done", 32'(done), 32'd0);
    chk("p7_rst_in_ready", 32'(in_ready), 32'd1);
    chk("p7_rst_len", 32'(len), 32'd0);
    in_valid = 1'b1; mcode = 6'(-1);
    collect(3, v);
    chk("m1_bits", v, 32'b011);
    @(negedge clk);
    chk("m1_done", 32'(done), 32'd1);

    // back-to-back +1, -16, +11 with random out_ready
    cstart = cap.size();
    astart = m_acc.size();
    push(1); push(-16); push(11);
    drain();
    chk("b2b_count", 32'(cap.size() - cstart), 32'd25);
    v = '0;
    for (int i = cstart; i < cap.size(); i++) v = {v[30:0], cap[i]};
    chk("b2b_stream", v, 32'(25'b0100000001100100000100010));

    // random traffic, mostly legal
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom % 3) != 0;
      if ($urandom % 8 == 0) mcode = 6'($urandom);
      else mcode = 6'(int'($urandom_range(0, 32)) - 16);
      out_ready = ($urandom % 4) != 0;
      @(negedge clk);
    end
    drain();

    decode(cap, cstart, res, ok);
    chk("dec_ok", 32'(ok), 32'd1);
    chk("dec_count", 32'(res.size()), 32'(m_acc.size() - astart));
    for (int i = 0; i < res.size() && (astart + i) < m_acc.size(); i++)
      chk("dec_val", 32'(res[i]), 32'(m_acc[astart+i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
